multibank_arbiter: RTL and testbench
====================================

# multibank_arbiter

Parametrised N-bank arbiter between the CPU-side memory port and N address-interleaved cache banks, and between those banks and a single shared upstream memory port. CPU requests are steered to a bank by address bits and held to that bank until it responds; bank miss traffic competes for upstream memory under a registered round-robin arbiter that holds each grant until `mem_resp`. It is the next generation of the two-bank arbiter and sits between the pipeline's data port and the L2/physical-memory interface.

## Interface
- `NUM_BANKS`, 2: bank count; power of two, 2..8. `SELW = $clog2(NUM_BANKS)`.
- `BANK_SEL_LSB`, 5: LSB of the bank-select field `addr[BANK_SEL_LSB +: SELW]`.
- `LWIDTH`, 32: CPU-side data width.
- `HWIDTH`, 256: line width on the bank/upstream side.

Ports. Per-bank buses are packed, with bank i at slice `[i*W +: W]`.
- `clk  in  1  clock`
- `rst_n  in  1  reset, asynchronous, active-low`
- `addr  in  32  CPU address`
- `wdata  in  LWIDTH  CPU write data`
- `wmask  in  4  CPU byte mask`
- `read`, `write`  in  1  CPU strobes, held until `resp`
- `resp  out  1  CPU response`
- `rdata  out  LWIDTH  CPU read data`
- `b_addr  out  NUM_BANKS*32  address to each bank`
- `b_wdata  out  NUM_BANKS*LWIDTH  write data to each bank`
- `b_wmask  out  NUM_BANKS*4  byte mask to each bank`
- `b_read`, `b_write`  out  NUM_BANKS  per-bank strobes
- `b_resp  in  NUM_BANKS  per-bank response`
- `b_rdata  in  NUM_BANKS*LWIDTH  per-bank read data`
- `b_mem_read`, `b_mem_write`  in  NUM_BANKS  bank upstream requests
- `b_mem_addr  in  NUM_BANKS*32  bank upstream address`
- `b_mem_wdata  in  NUM_BANKS*HWIDTH  bank upstream write line`
- `b_mem_resp  out  NUM_BANKS  upstream response to each bank`
- `b_mem_rdata  out  NUM_BANKS*HWIDTH  upstream line to each bank`
- `mem_read`, `mem_write`  out  1  upstream strobes
- `mem_addr  out  32`, `mem_wdata  out  HWIDTH`
- `mem_resp  in  1`, `mem_rdata  in  HWIDTH`

## Operation

**CPU side (FSM `C_IDLE` / `C_WAIT`, register `csel[SELW-1:0]`)**
- Active bank `act` is `addr` field in `C_IDLE` and `csel` in `C_WAIT`.
- `b_read[act]`, `b_write[act]`, `b_wmask[act]` and `b_wdata[act]` carry the CPU values. All other banks get 0. `b_addr` broadcasts `addr` to all banks.
- `resp = b_resp[act] & (read|write)`; `rdata = b_rdata[act]`.
- Transitions:
  - `C_IDLE` with `(read|write)` and `!b_resp[act]`: `csel <= field`, go to `C_WAIT`.
  - `C_IDLE` with `(read|write)` and `b_resp[act]` (same-cycle hit): stay in `C_IDLE`.
  - `C_WAIT` with `b_resp[csel]`: go to `C_IDLE`.
  - A changing `addr` field during `C_WAIT` does not redirect the request.

**Upstream side (FSM `U_IDLE` / `U_BUSY`, registers `gnt[SELW-1:0]`, `last[SELW-1:0]`)**
- Per-bank request is `req[i] = b_mem_read[i] | b_mem_write[i]`.
- `U_IDLE` with any `req`: `gnt <=` first requesting bank searching `last+1, last+2, …` modulo `NUM_BANKS`; go to `U_BUSY`.
- In `U_BUSY`, `mem_read`, `mem_write`, `mem_addr` and `mem_wdata` come from bank `gnt`. `b_mem_resp[gnt] = mem_resp` and `b_mem_rdata[gnt] = mem_rdata`; all other banks get 0.
- In `U_IDLE`, `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, `b_mem_resp` and `b_mem_rdata` are all 0.
- `U_BUSY` with `mem_resp`: `last <= gnt`, go to `U_IDLE`.
  - The mandatory idle cycle lets the bank drop its request, so a stale request is never re-granted.
- The granted bank dropping its request before `mem_resp` is illegal; upstream strobes simply follow the bank.

**Reset (asynchronous, `rst_n=0`)**
- State values: `C_IDLE`, `U_IDLE`, `csel=0`, `gnt=0`, `last=NUM_BANKS-1` (so bank 0 has first priority).
- Upstream outputs and `b_mem_*` outputs are 0 immediately.
- A reset mid-transaction abandons it; there is no replay.

## Timing
- CPU path is combinational in both directions: zero added latency, hit response in the same cycle.
- Upstream grant is registered: `mem_read` rises 1 cycle after the first cycle `req[i]`=1.
- `b_mem_resp` is combinational from `mem_resp`.
- Back-to-back upstream transactions are separated by exactly 1 idle cycle.
- Simultaneous CPU traffic and upstream transactions are independent. Both FSMs may change state in the same cycle.
- Worst-case wait for a requesting bank: `NUM_BANKS-1` full upstream transactions.

## Test plan
- **Steering:** `NUM_BANKS=4`, `addr=0x0000_0040` (field=2), `read=1`, `b_resp=4'b0100` → `b_read=4'b0100`, `resp=1` same cycle, `rdata=b_rdata[2]`, FSM stays in `C_IDLE`.
- **Miss hold:** `addr` field=1 with no `b_resp`, then `addr` switched to field 3 while waiting → `b_read` stays `4'b0010` until `b_resp[1]`, then `C_IDLE`.
- **Round-robin:** after reset, all four banks request continuously and each `mem_resp` arrives 3 cycles after grant → grant order 0,1,2,3,0; one idle cycle between grants.
- **Isolation:** bank 2 granted with `b_mem_addr[2]=0x1234_5600` → `mem_addr=0x1234_5600`; `mem_resp` with `mem_rdata=all 0xA5` → only `b_mem_resp[2]=1`, other `b_mem_rdata` slices 0.
- **Grant latency:** single bank 1 raises `b_mem_write` at cycle t → `mem_write=1` at t+1 with bank 1 `mem_wdata`.
- **Async reset mid-transaction:** `rst_n` dropped between clock edges during `U_BUSY` → `mem_read`, `mem_write`, `b_mem_resp` = 0 immediately; after release with banks 1 and 3 requesting → bank 1 granted first.

Source files
------------

// File: rtl/multibank_arbiter.sv
// multibank_arbiter: steers CPU requests to one of NUM_BANKS address-interleaved
// cache banks and round-robin arbitrates bank miss traffic onto one upstream port.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   addr/wdata/wmask/read/write        CPU request (strobes held until resp)
//   resp/rdata                         CPU response (combinational from active bank)
//   b_addr/b_wdata/b_wmask/b_read/b_write   per-bank request (bank i at [i*W +: W])
//   b_resp/b_rdata                     per-bank response
//   b_mem_read/b_mem_write/b_mem_addr/b_mem_wdata   bank upstream requests
//   b_mem_resp/b_mem_rdata             upstream response routed to granted bank
//   mem_read/mem_write/mem_addr/mem_wdata/mem_resp/mem_rdata   shared upstream port
module multibank_arbiter #(
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned BANK_SEL_LSB = 5,
  parameter int unsigned LWIDTH       = 32,
  parameter int unsigned HWIDTH       = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   addr,
  input  logic [LWIDTH-1:0]             wdata,
  input  logic [3:0]                    wmask,
  input  logic                          read,
  input  logic                          write,
  output logic                          resp,
  output logic [LWIDTH-1:0]             rdata,
  output logic [NUM_BANKS*32-1:0]       b_addr,
  output logic [NUM_BANKS*LWIDTH-1:0]   b_wdata,
  output logic [NUM_BANKS*4-1:0]        b_wmask,
  output logic [NUM_BANKS-1:0]          b_read,
  output logic [NUM_BANKS-1:0]          b_write,
  input  logic [NUM_BANKS-1:0]          b_resp,
  input  logic [NUM_BANKS*LWIDTH-1:0]   b_rdata,
  input  logic [NUM_BANKS-1:0]          b_mem_read,
  input  logic [NUM_BANKS-1:0]          b_mem_write,
  input  logic [NUM_BANKS*32-1:0]       b_mem_addr,
  input  logic [NUM_BANKS*HWIDTH-1:0]   b_mem_wdata,
  output logic [NUM_BANKS-1:0]          b_mem_resp,
  output logic [NUM_BANKS*HWIDTH-1:0]   b_mem_rdata,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [31:0]                   mem_addr,
  output logic [HWIDTH-1:0]             mem_wdata,
  input  logic                          mem_resp,
  input  logic [HWIDTH-1:0]             mem_rdata
);

  localparam int unsigned SELW = $clog2(NUM_BANKS);

  localparam logic [0:0] C_IDLE = 1'b0;
  localparam logic [0:0] C_WAIT = 1'b1;
  localparam logic [0:0] U_IDLE = 1'b0;
  localparam logic [0:0] U_BUSY = 1'b1;

  // ---------------- CPU side ----------------
  logic [0:0]      r_cstate, w_cstate_nxt;
  logic [SELW-1:0] r_csel, w_csel_nxt;
  logic [SELW-1:0] w_field, w_act;
  logic            w_cpu_req, w_act_resp, w_csel_resp;

  assign w_field   = addr[BANK_SEL_LSB +: SELW];
  assign w_cpu_req = read | write;
  // Once a miss is pending the bank is pinned; later addr changes are ignored.
  assign w_act     = (r_cstate == C_WAIT) ? r_csel : w_field;
  assign b_addr    = {NUM_BANKS{addr}};
  assign resp      = w_cpu_req & w_act_resp;

  // Route CPU request to the active bank and its response back.
  always_comb begin
    b_read      = '0;
    b_write     = '0;
    b_wmask     = '0;
    b_wdata     = '0;
    rdata       = '0;
    w_act_resp  = 1'b0;
    w_csel_resp = 1'b0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (SELW'(i) == w_act) begin
        b_read[i]                     = read;
        b_write[i]                    = write;
        b_wmask[i*4 +: 4]             = wmask;
        b_wdata[i*LWIDTH +: LWIDTH]   = wdata;
        rdata                         = b_rdata[i*LWIDTH +: LWIDTH];
        w_act_resp                    = b_resp[i];
      end
      if (SELW'(i) == r_csel) begin
        w_csel_resp = b_resp[i];
      end
    end
  end

  // CPU FSM next state.
  always_comb begin
    w_cstate_nxt = r_cstate;
    w_csel_nxt   = r_csel;
    case (r_cstate)
      C_IDLE: begin
        if (w_cpu_req && !w_act_resp) begin
          w_csel_nxt   = w_field;
          w_cstate_nxt = C_WAIT;
        end
      end
      C_WAIT: begin
        if (w_csel_resp) begin
          w_cstate_nxt = C_IDLE;
        end
      end
      default: w_cstate_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cstate <= C_IDLE;
      r_csel   <= '0;
    end else begin
      r_cstate <= w_cstate_nxt;
      r_csel   <= w_csel_nxt;
    end
  end

  // ---------------- Upstream side ----------------
  logic [0:0]           r_ustate, w_ustate_nxt;
  logic [SELW-1:0]      r_gnt, w_gnt_nxt, r_last, w_last_nxt, w_rr_pick;
  logic [NUM_BANKS-1:0] w_req;
  logic                 w_found;

  assign w_req = b_mem_read | b_mem_write;

  // Round-robin search starting just after the last served bank; wraps mod 2^SELW.
  always_comb begin
    w_rr_pick = r_last;
    w_found   = 1'b0;
    for (int unsigned k = 1; k <= NUM_BANKS; k++) begin
      if (!w_found && w_req[SELW'(r_last + SELW'(k))]) begin
        w_rr_pick = SELW'(r_last + SELW'(k));
        w_found   = 1'b1;
      end
    end
  end

  // Upstream mux: everything is zero unless a grant is outstanding.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    b_mem_resp  = '0;
    b_mem_rdata = '0;
    if (r_ustate == U_BUSY) begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        if (SELW'(i) == r_gnt) begin
          mem_read                        = b_mem_read[i];
          mem_write                       = b_mem_write[i];
          mem_addr                        = b_mem_addr[i*32 +: 32];
          mem_wdata                       = b_mem_wdata[i*HWIDTH +: HWIDTH];
          b_mem_resp[i]                   = mem_resp;
          b_mem_rdata[i*HWIDTH +: HWIDTH] = mem_rdata;
        end
      end
    end
  end

  // Upstream FSM next state; returning to idle after each response gives the
  // served bank one cycle to drop its request before the next arbitration.
  always_comb begin
    w_ustate_nxt = r_ustate;
    w_gnt_nxt    = r_gnt;
    w_last_nxt   = r_last;
    case (r_ustate)
      U_IDLE: begin
        if (w_found) begin
          w_gnt_nxt    = w_rr_pick;
          w_ustate_nxt = U_BUSY;
        end
      end
      U_BUSY: begin
        if (mem_resp) begin
          w_last_nxt   = r_gnt;
          w_ustate_nxt = U_IDLE;
        end
      end
      default: w_ustate_nxt = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ustate <= U_IDLE;
      r_gnt    <= '0;
      r_last   <= SELW'(NUM_BANKS - 1);
    end else begin
      r_ustate <= w_ustate_nxt;
      r_gnt    <= w_gnt_nxt;
      r_last   <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_multibank_arbiter.sv
// Self-checking bench for multibank_arbiter with NUM_BANKS=4: directed scenarios
// followed by randomized traffic compared against a transaction-level model.
module tb_multibank_arbiter;

  localparam int unsigned NB = 4;
  localparam int unsigned LW = 32;
  localparam int unsigned HW = 256;
  localparam int unsigned SL = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       addr;
  logic [LW-1:0]     wdata;
  logic [3:0]        wmask;
  logic              read, write;
  logic              resp;
  logic [LW-1:0]     rdata;
  logic [NB*32-1:0]  b_addr;
  logic [NB*LW-1:0]  b_wdata;
  logic [NB*4-1:0]   b_wmask;
  logic [NB-1:0]     b_read, b_write, b_resp;
  logic [NB*LW-1:0]  b_rdata;
  logic [NB-1:0]     b_mem_read, b_mem_write, b_mem_resp;
  logic [NB*32-1:0]  b_mem_addr;
  logic [NB*HW-1:0]  b_mem_wdata, b_mem_rdata;
  logic              mem_read, mem_write, mem_resp;
  logic [31:0]       mem_addr;
  logic [HW-1:0]     mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  multibank_arbiter #(
    .NUM_BANKS(NB), .BANK_SEL_LSB(SL), .LWIDTH(LW), .HWIDTH(HW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wmask(wmask),
    .read(read), .write(write), .resp(resp), .rdata(rdata),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_wmask(b_wmask),
    .b_read(b_read), .b_write(b_write), .b_resp(b_resp), .b_rdata(b_rdata),
    .b_mem_read(b_mem_read), .b_mem_write(b_mem_write), .b_mem_addr(b_mem_addr),
    .b_mem_wdata(b_mem_wdata), .b_mem_resp(b_mem_resp), .b_mem_rdata(b_mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic logic [HW-1:0] rand_line();
    logic [HW-1:0] v;
    for (int j = 0; j < int'(HW / 32); j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // First requesting bank after 'last', cyclically; -1 when nobody requests.
  function automatic int rr_pick(int last, logic [NB-1:0] req);
    for (int k = 1; k <= int'(NB); k++) begin
      if (req[(last + k) % int'(NB)]) return (last + k) % int'(NB);
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    addr = '0; wdata = '0; wmask = '0; read = 1'b0; write = 1'b0;
    b_resp = '0; b_rdata = '0;
    b_mem_read = '0; b_mem_write = '0; b_mem_addr = '0; b_mem_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    mem_resp = 1'b1;
    mem_rdata = {(HW/8){8'hFF}};
    b_mem_read = 4'hF;
    #3;
    n_checks++;
    if ({mem_read, mem_write} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {mem_read, mem_write});
    else n_pass++;
    n_checks++;
    if (b_mem_resp !== 4'b0000) $display("FAIL reset_bmemresp: got %b want 0000", b_mem_resp);
    else n_pass++;
    n_checks++;
    if (b_mem_rdata[HW-1:0] !== '0) $display("FAIL reset_bmemrdata: got %h want 0", b_mem_rdata[HW-1:0]);
    else n_pass++;
    step();
    n_checks++;
    if ({mem_read, mem_addr} !== 33'h0) $display("FAIL reset_nogrant: got %h want 0", {mem_read, mem_addr});
    else n_pass++;
  endtask

  task automatic test_steering();
    do_reset();
    for (int i = 0; i < int'(NB); i++) b_rdata[i*LW +: LW] = 32'hCAFE_0000 + 32'(i);
    addr = 32'h0000_0040;
    read = 1'b1;
    b_resp = 4'b0100;
    #1;
    n_checks++;
    if ({b_read, b_write} !== 8'b0100_0000) $display("FAIL steer_strobes: got %b want 01000000", {b_read, b_write});
    else n_pass++;
    n_checks++;
    if ({resp, rdata} !== {1'b1, 32'hCAFE_0002}) $display("FAIL steer_resp: got %h want 1cafe0002", {resp, rdata});
    else n_pass++;
    n_checks++;
    if (b_addr !== {NB{32'h0000_0040}}) $display("FAIL steer_baddr: got %h want broadcast 40", b_addr);
    else n_pass++;
    step();
    // A hit leaves the FSM idle, so a new field steers immediately.
    addr = 32'h0;
    b_resp = 4'b0001;
    #1;
    n_checks++;
    if (b_read !== 4'b0001) $display("FAIL steer_stay_idle: got %b want 0001", b_read);
    else n_pass++;
    step();
    clear_inputs();
  endtask

  task automatic test_miss_hold();
    do_reset();
    for (int i = 0; i < int'(NB); i++) b_rdata[i*LW +: LW] = 32'hBEEF_0000 + 32'(i);
    addr = 32'h0000_0020;
    read = 1'b1;
    #1;
    n_checks++;
    if ({b_read, resp} !== 5'b0010_0) $display("FAIL miss_first: got %b want 00100", {b_read, resp});
    else n_pass++;
    step();
    addr = 32'h0000_0060;
    b_resp = 4'b1000;
    #1;
    n_checks++;
    if ({b_read, resp} !== 5'b0010_0) $display("FAIL miss_redirect: got %b want 00100", {b_read, resp});
    else n_pass++;
    step();
    n_checks++;
    if (b_read !== 4'b0010) $display("FAIL miss_still_held: got %b want 0010", b_read);
    else n_pass++;
    b_resp = 4'b0010;
    #1;
    n_checks++;
    if ({resp, rdata} !== {1'b1, 32'hBEEF_0001}) $display("FAIL miss_resp: got %h want 1beef0001", {resp, rdata});
    else n_pass++;
    step();
    b_resp = 4'b1000;
    #1;
    n_checks++;
    if ({b_read, resp} !== 5'b1000_1) $display("FAIL miss_back_idle: got %b want 10001", {b_read, resp});
    else n_pass++;
    step();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    for (int i = 0; i < int'(NB); i++) b_mem_addr[i*32 +: 32] = 32'h1000 * 32'(i + 1);
    b_mem_read = 4'hF;
    #1;
    n_checks++;
    if (mem_read !== 1'b0) $display("FAIL rr_pre_grant: got %b want 0", mem_read);
    else n_pass++;
    step();
    for (int g = 0; g < 5; g++) begin
      e = g % int'(NB);
      n_checks++;
      if ({mem_read, mem_addr} !== {1'b1, 32'h1000 * 32'(e + 1)})
        $display("FAIL rr_grant%0d: got %h want %h", g, {mem_read, mem_addr}, {1'b1, 32'h1000 * 32'(e + 1)});
      else n_pass++;
      step();
      step();
      mem_resp = 1'b1;
      #1;
      n_checks++;
      if (b_mem_resp !== 4'(1 << e)) $display("FAIL rr_resp%0d: got %b want %b", g, b_mem_resp, 4'(1 << e));
      else n_pass++;
      step();
      mem_resp = 1'b0;
      #1;
      n_checks++;
      if (mem_read !== 1'b0) $display("FAIL rr_idle%0d: got %b want 0", g, mem_read);
      else n_pass++;
      step();
    end
    clear_inputs();
  endtask

  task automatic test_isolation();
    logic [HW-1:0] wline;
    logic [HW-1:0] exp_slice;
    do_reset();
    for (int i = 0; i < int'(NB); i++) begin
      b_mem_addr[i*32 +: 32] = 32'hDEAD_0000 + 32'(i);
      b_mem_wdata[i*HW +: HW] = rand_line();
    end
    b_mem_addr[2*32 +: 32] = 32'h1234_5600;
    wline = rand_line();
    b_mem_wdata[2*HW +: HW] = wline;
    b_mem_read = 4'b0100;
    step();
    n_checks++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h1234_5600}) $display("FAIL iso_addr: got %h want 112345600", {mem_read, mem_addr});
    else n_pass++;
    n_checks++;
    if (mem_wdata !== wline) $display("FAIL iso_wdata: got %h want %h", mem_wdata, wline);
    else n_pass++;
    mem_resp = 1'b1;
    mem_rdata = {(HW/8){8'hA5}};
    #1;
    n_checks++;
    if (b_mem_resp !== 4'b0100) $display("FAIL iso_bresp: got %b want 0100", b_mem_resp);
    else n_pass++;
    for (int i = 0; i < int'(NB); i++) begin
      exp_slice = (i == 2) ? {(HW/8){8'hA5}} : '0;
      n_checks++;
      if (b_mem_rdata[i*HW +: HW] !== exp_slice) $display("FAIL iso_rdata%0d: got %h want %h", i, b_mem_rdata[i*HW +: HW], exp_slice);
      else n_pass++;
    end
    step();
    mem_resp = 1'b0;
    b_mem_read = '0;
    #1;
    n_checks++;
    if ({mem_read, b_mem_resp} !== 5'b0) $display("FAIL iso_release: got %b want 00000", {mem_read, b_mem_resp});
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_grant_latency();
    logic [HW-1:0] wline;
    do_reset();
    wline = rand_line();
    b_mem_wdata[1*HW +: HW] = wline;
    b_mem_addr[1*32 +: 32] = 32'h0000_ABC0;
    b_mem_write = 4'b0010;
    #1;
    n_checks++;
    if (mem_write !== 1'b0) $display("FAIL lat_t0: got %b want 0", mem_write);
    else n_pass++;
    step();
    n_checks++;
    if ({mem_write, mem_read} !== 2'b10) $display("FAIL lat_t1: got %b want 10", {mem_write, mem_read});
    else n_pass++;
    n_checks++;
    if (mem_wdata !== wline) $display("FAIL lat_wdata: got %h want %h", mem_wdata, wline);
    else n_pass++;
    mem_resp = 1'b1;
    step();
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < int'(NB); i++) b_mem_addr[i*32 +: 32] = 32'h100 * 32'(i + 1);
    b_mem_read = 4'b0100;
    step();
    n_checks++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h300}) $display("FAIL arst_busy: got %h want 100000300", {mem_read, mem_addr});
    else n_pass++;
    mem_resp = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_read, mem_write, b_mem_resp, mem_addr} !== 38'h0)
      $display("FAIL arst_immediate: got %h want 0", {mem_read, mem_write, b_mem_resp, mem_addr});
    else n_pass++;
    mem_resp = 1'b0;
    b_mem_read = 4'b1010;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h200}) $display("FAIL arst_regrant: got %h want 100000200", {mem_read, mem_addr});
    else n_pass++;
    mem_resp = 1'b1;
    step();
    clear_inputs();
  endtask

  // Randomized traffic against a transaction-level model: one pending-bank
  // number for the CPU and a busy/granted/last-served triple for upstream.
  task automatic test_random();
    int            m_cpend, m_gnt, m_last, e_act, p, op;
    bit            m_busy;
    logic [NB-1:0] m_breq, m_bwr;
    logic [NB-1:0] e_bread, e_bwrite, e_bmresp;
    logic [NB*LW-1:0] e_bwdata;
    logic [NB*4-1:0]  e_bwmask;
    logic [HW-1:0]    e_slice;
    logic             e_mr, e_mw;
    logic [31:0]      e_maddr;
    logic [HW-1:0]    e_mwdata;
    do_reset();
    m_cpend = -1; m_busy = 1'b0; m_gnt = 0; m_last = int'(NB) - 1;
    m_breq = '0; m_bwr = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (m_cpend < 0) begin
        op = $urandom_range(2);
        read = (op == 1); write = (op == 2);
        wdata = $urandom; wmask = 4'($urandom);
      end
      addr = $urandom;
      b_resp = 4'($urandom);
      for (int i = 0; i < int'(NB); i++) begin
        b_rdata[i*LW +: LW] = $urandom;
        b_mem_addr[i*32 +: 32] = $urandom;
        b_mem_wdata[i*HW +: HW] = rand_line();
        if (!m_breq[i] && $urandom_range(3) == 0) begin
          m_breq[i] = 1'b1;
          m_bwr[i] = 1'($urandom_range(1));
        end
      end
      b_mem_read = m_breq & ~m_bwr;
      b_mem_write = m_breq & m_bwr;
      mem_resp = ($urandom_range(2) == 0);
      mem_rdata = rand_line();
      #1;
      e_act = (m_cpend >= 0) ? m_cpend : int'(addr[SL +: 2]);
      e_bread = '0; e_bwrite = '0; e_bwdata = '0; e_bwmask = '0;
      e_bread[e_act] = read; e_bwrite[e_act] = write;
      e_bwdata[e_act*LW +: LW] = wdata; e_bwmask[e_act*4 +: 4] = wmask;
      e_mr = 1'b0; e_mw = 1'b0; e_maddr = '0; e_mwdata = '0; e_bmresp = '0;
      if (m_busy) begin
        e_mr = b_mem_read[m_gnt]; e_mw = b_mem_write[m_gnt];
        e_maddr = b_mem_addr[m_gnt*32 +: 32]; e_mwdata = b_mem_wdata[m_gnt*HW +: HW];
        e_bmresp[m_gnt] = mem_resp;
      end
      n_checks++;
      if ({b_read, b_write} !== {e_bread, e_bwrite}) $display("FAIL rnd_strobes c%0d: got %b want %b", cyc, {b_read, b_write}, {e_bread, e_bwrite});
      else n_pass++;
      n_checks++;
      if ({resp, rdata} !== {((read | write) & b_resp[e_act]), b_rdata[e_act*LW +: LW]})
        $display("FAIL rnd_resp c%0d: got %h want %h", cyc, {resp, rdata}, {((read | write) & b_resp[e_act]), b_rdata[e_act*LW +: LW]});
      else n_pass++;
      n_checks++;
      if ({b_addr, b_wdata, b_wmask} !== {{NB{addr}}, e_bwdata, e_bwmask})
        $display("FAIL rnd_bdata c%0d: got %h want %h", cyc, {b_addr, b_wdata, b_wmask}, {{NB{addr}}, e_bwdata, e_bwmask});
      else n_pass++;
      n_checks++;
      if ({mem_read, mem_write, mem_addr, b_mem_resp} !== {e_mr, e_mw, e_maddr, e_bmresp})
        $display("FAIL rnd_up c%0d: got %h want %h", cyc, {mem_read, mem_write, mem_addr, b_mem_resp}, {e_mr, e_mw, e_maddr, e_bmresp});
      else n_pass++;
      n_checks++;
      if (mem_wdata !== e_mwdata) $display("FAIL rnd_mwdata c%0d: got %h want %h", cyc, mem_wdata, e_mwdata);
      else n_pass++;
      for (int i = 0; i < int'(NB); i++) begin
        e_slice = (m_busy && i == m_gnt) ? mem_rdata : '0;
        n_checks++;
        if (b_mem_rdata[i*HW +: HW] !== e_slice) $display("FAIL rnd_bmrdata c%0d b%0d: got %h want %h", cyc, i, b_mem_rdata[i*HW +: HW], e_slice);
        else n_pass++;
      end
      if (m_cpend < 0) begin
        if ((read | write) && !b_resp[e_act]) m_cpend = e_act;
      end else if (b_resp[m_cpend]) begin
        m_cpend = -1;
      end
      if (m_busy) begin
        if (mem_resp) begin
          m_breq[m_gnt] = 1'b0;
          m_last = m_gnt;
          m_busy = 1'b0;
        end
      end else begin
        p = rr_pick(m_last, m_breq);
        if (p >= 0) begin
          m_gnt = p;
          m_busy = 1'b1;
        end
      end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_steering();
    test_miss_hold();
    test_round_robin();
    test_isolation();
    test_grant_latency();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
